// File: rtl/tpu_cmd_responder.sv
// tpu_cmd_responder: TPU command responder holding A, B and C matrices.
// IDLE accepts loads/reads; MATMUL performs C += A*B over DIM cycles.
module tpu_cmd_responder #(
   parameter int DIM    = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int IDX_W  = $clog2(DIM)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [2:0]        cmd_op_i,
   input  logic [IDX_W-1:0]  cmd_row_i,
   input  logic [IDX_W-1:0]  cmd_col_i,
   input  logic [ACC_W-1:0]  cmd_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              rsp_valid_o,
   output logic [ACC_W-1:0]  rsp_data_o
);
   localparam logic [2:0] OP_MATMUL = 3'd0;
   localparam logic [2:0] OP_LAM    = 3'd1;
   localparam logic [2:0] OP_LBM    = 3'd2;
   localparam logic [2:0] OP_LACC   = 3'd3;
   localparam logic [2:0] OP_RACC   = 3'd4;

   typedef enum logic {S_IDLE, S_MATMUL} state_t;

   state_t                   r_state, w_next;
   logic [IDX_W-1:0]         r_k;
   logic signed [DATA_W-1:0] r_a [DIM][DIM];
   logic signed [DATA_W-1:0] r_b [DIM][DIM];
   logic [ACC_W-1:0]         r_c [DIM][DIM];
   logic [ACC_W-1:0]         w_prod [DIM][DIM];
   logic                     w_acc;

   assign cmd_ready_o = (r_state == S_IDLE) & rst_n_i;
   assign w_acc       = cmd_valid_i & cmd_ready_o;

   always_comb begin
      w_next = r_state;
      busy_o = r_state == S_MATMUL;
      done_o = busy_o && (r_k == IDX_W'(DIM - 1));
      if (done_o)
         w_next = S_IDLE;
      else if (!busy_o && w_acc && cmd_op_i == OP_MATMUL)
         w_next = S_MATMUL;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         r_k     <= busy_o ? r_k + IDX_W'(1) : '0;
      end
   end

   // Signed operands widened to ACC_W first, so the product is already sign-extended
   always_comb begin
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            w_prod[i][j] = ACC_W'(r_a[i][r_k]) * ACC_W'(r_b[r_k][j]);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
               r_a[i][j] <= '0;
               r_b[i][j] <= '0;
               r_c[i][j] <= '0;
            end
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
      end else begin
         rsp_valid_o <= w_acc && cmd_op_i == OP_RACC;
         if (w_acc && cmd_op_i == OP_RACC)
            rsp_data_o <= r_c[cmd_row_i][cmd_col_i];
         if (w_acc && cmd_op_i == OP_LAM)
            r_a[cmd_row_i][cmd_col_i] <= cmd_data_i[DATA_W-1:0];
         if (w_acc && cmd_op_i == OP_LBM)
            r_b[cmd_row_i][cmd_col_i] <= cmd_data_i[DATA_W-1:0];
         if (w_acc && cmd_op_i == OP_LACC)
            r_c[cmd_row_i][cmd_col_i] <= cmd_data_i;
         if (busy_o)
            for (int i = 0; i < DIM; i++)
               for (int j = 0; j < DIM; j++)
                  r_c[i][j] <= r_c[i][j] + w_prod[i][j];
      end
   end
endmodule
